// File: rtl/hex_display_mux_if.sv
// Display-side signal bundle for hex_display_mux: the value, its load strobe
// and the display controls go into the multiplexer, and the registered
// segment, anode and frame signals come out of it.
interface hex_display_mux_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] num;
    logic                ld;
    logic                en;
    logic                lzb;
    logic [DIGITS-1:0]   blink_mask;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (
        output num, ld, en, lzb, blink_mask,
        input  seg, an, frame
    );

    modport slave (
        input  num, ld, en, lzb, blink_mask,
        output seg, an, frame
    );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed driver for a DIGITS-wide common-anode hex display.
// A shadow register holds the shown value. A free-running prescaler steps
// the digit index, and seg/an are registered from the current index and
// shadow. Leading-zero blanking and per-digit blinking are supported, and
// frame pulses once per completed scan.
module hex_display_mux #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_display_mux_if.slave  bus
);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    logic                wrapped;
    logic                advance;
    logic                wrap;
    logic [3:0]          nib;
    logic                lz_here;
    logic                blink_here;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;

    // Active-low gfedcba pattern for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign advance = (pre == LAST_PRE);
    assign wrap    = advance && (idx == LAST_IDX);

    // Shadow copy of num, captured on every load strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (bus.ld) begin
            shadow <= bus.num;
        end
    end

    // Free-running prescaler and digit index; wrapped marks a completed scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrap;
            if (advance) begin
                pre <= '0;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Blink phase flips after every BLINK_FRAMES completed scans
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == LAST_BLINK) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Select the current digit and decide anode drive and blanking
    always_comb begin
        nib        = '0;
        lz_here    = 1'b0;
        blink_here = 1'b0;
        an_d       = '1;
        seg_d      = 7'h7F;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            an_d[j] = ~(bus.en && (idx == IW'(j)));
            if (idx == IW'(j)) begin
                nib        = shadow[4*j +: 4];
                blink_here = bus.blink_mask[j];
                // digit 0 is never a leading zero
                lz_here    = (j != 0);
                for (int unsigned m = j; m < DIGITS; m++) begin
                    if (shadow[4*m +: 4] != 4'h0) begin
                        lz_here = 1'b0;
                    end
                end
            end
        end
        if (bus.en && !(bus.lzb && lz_here) && !(phase && blink_here)) begin
            seg_d = hex7(nib);
        end
    end

    // Registered display outputs; frame lands with the return to digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an    <= '1;
            bus.seg   <= 7'h7F;
            bus.frame <= 1'b0;
        end else begin
            bus.an    <= an_d;
            bus.seg   <= seg_d;
            bus.frame <= wrapped;
        end
    end
endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Stimulus queues the expected display sequence (anode, segments, dwell in
// clocks). A monitor pops one entry each time the display output changes.
// It also checks the frame pulse spacing and its alignment with digit 0.
module tb_hex_display_mux;
    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int unsigned dwell;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned e = 0;
    bit          mon_on = 1'b0;
    disp_t       sb[$];

    hex_display_mux_if #(.DIGITS(4)) bus ();

    hex_display_mux #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input int unsigned d);
        disp_t x;
        x.an = a;
        x.seg = s;
        x.dwell = d;
        sb.push_back(x);
    endtask

    task automatic adv_to(input int unsigned k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    // Monitor: compare each new display state against the scoreboard
    initial begin : monitor
        logic [3:0]  p_an;
        logic [6:0]  p_seg;
        int unsigned chg_cyc;
        int unsigned exp_dwell;
        int unsigned last_frame;
        bit          have_prev;
        bit          frame_valid;
        disp_t       x;
        wait (mon_on);
        p_an = bus.an;
        p_seg = bus.seg;
        have_prev = 1'b0;
        frame_valid = 1'b0;
        chg_cyc = 0;
        exp_dwell = 0;
        last_frame = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                frame_valid = 1'b0;
            end else if (bus.frame) begin
                if (frame_valid) chk("frame_gap", cyc - last_frame, 16);
                if (bus.en) chk("frame_align", {28'h0, bus.an}, 32'hE);
                frame_valid = 1'b1;
                last_frame = cyc;
            end
            if (bus.an !== p_an || bus.seg !== p_seg) begin
                if (have_prev && exp_dwell != 0) chk("dwell", cyc - chg_cyc, exp_dwell);
                if (sb.size() == 0) begin
                    chk("unexpected_change", {21'h0, bus.an, bus.seg}, 32'hFFFF_FFFF);
                    exp_dwell = 0;
                end else begin
                    x = sb.pop_front();
                    chk("disp", {21'h0, bus.an, bus.seg}, {21'h0, x.an, x.seg});
                    exp_dwell = x.dwell;
                end
                have_prev = 1'b1;
                chg_cyc = cyc;
                p_an = bus.an;
                p_seg = bus.seg;
            end
        end
    end

    // Directed stimulus
    initial begin : stim
        rst_n = 1'b1;
        bus.num = '0;
        bus.ld = 1'b0;
        bus.en = 1'b1;
        bus.lzb = 1'b0;
        bus.blink_mask = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {28'h0, bus.an}, 32'hF);
        chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
        chk("rst_frame", {31'h0, bus.frame}, 32'h0);
        mon_on = 1'b1;

        // 12AF scanned right to left; first clock still shows the cleared shadow
        push(4'hE, 7'h40, 1);
        push(4'hE, 7'h0E, 3);
        for (int f = 0; f < 2; f++) begin
            if (f > 0) push(4'hE, 7'h0E, 4);
            push(4'hD, 7'h08, 4);
            push(4'hB, 7'h24, 4);
            push(4'h7, 7'h79, 4);
        end
        rst_n = 1'b1;
        bus.ld = 1'b1;
        bus.num = 16'h12AF;
        e = 0;
        adv_to(1);
        bus.ld = 1'b0;

        // 0005 with leading-zero blanking, loaded on the wrap edge
        adv_to(31);
        push(4'hE, 7'h12, 4);
        push(4'hD, 7'h7F, 4);
        push(4'hB, 7'h7F, 4);
        push(4'h7, 7'h7F, 4);
        bus.ld = 1'b1;
        bus.num = 16'h0005;
        bus.lzb = 1'b1;
        adv_to(32);
        bus.ld = 1'b0;

        // 0000 with leading-zero blanking: only digit 0 lit
        adv_to(47);
        push(4'hE, 7'h40, 4);
        push(4'hD, 7'h7F, 4);
        push(4'hB, 7'h7F, 4);
        push(4'h7, 7'h7F, 4);
        bus.ld = 1'b1;
        bus.num = 16'h0000;
        adv_to(48);
        bus.ld = 1'b0;

        // 8888 with digit 1 blinking: two frames on, two off, then on again
        adv_to(63);
        for (int f = 0; f < 5; f++) begin
            push(4'hE, 7'h00, 4);
            push(4'hD, (f == 2 || f == 3) ? 7'h7F : 7'h00, 4);
            push(4'hB, 7'h00, 4);
            push(4'h7, 7'h00, 4);
        end
        bus.ld = 1'b1;
        bus.num = 16'h8888;
        bus.blink_mask = 4'b0010;
        adv_to(64);
        bus.ld = 1'b0;
        bus.lzb = 1'b0;

        // Enable dropped mid-digit 0, restored during digit 2
        adv_to(140);
        push(4'hE, 7'h00, 2);
        push(4'hF, 7'h7F, 8);
        push(4'hB, 7'h00, 2);
        push(4'h7, 7'h00, 4);
        push(4'hE, 7'h00, 4);
        push(4'hD, 7'h7F, 4);
        push(4'hB, 7'h00, 4);
        push(4'h7, 7'h00, 4);
        adv_to(146);
        bus.en = 1'b0;
        adv_to(154);
        bus.en = 1'b1;

        // Asynchronous reset mid-scan; shadow cleared afterwards
        adv_to(170);
        push(4'hE, 7'h00, 3);
        push(4'hF, 7'h7F, 0);
        for (int f = 0; f < 2; f++) begin
            push(4'hE, 7'h40, 4);
            push(4'hD, 7'h40, 4);
            push(4'hB, 7'h40, 4);
            push(4'h7, 7'h40, 4);
        end
        push(4'hE, 7'h40, 0);
        adv_to(180);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {28'h0, bus.an}, 32'hF);
        chk("async_rst_seg", {25'h0, bus.seg}, 32'h7F);
        chk("async_rst_frame", {31'h0, bus.frame}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = 0;
        adv_to(36);
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_display_mux.md
HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of hex digits (legal 1..8).
REQ-002 SHALL provide parameter SCAN_DIV, default 1000, clk cycles each digit is driven (legal >= 2).
REQ-003 SHALL provide parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (legal >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port num  input  4*DIGITS  value to display; nibble i is digit i, digit 0 rightmost.
REQ-007 SHALL have port ld  input  1  load strobe; num is captured when high.
REQ-008 SHALL have port en  input  1  display enable.
REQ-009 SHALL have port lzb  input  1  leading-zero blanking enable.
REQ-010 SHALL have port blink_mask  input  DIGITS  per-digit blink enable.
REQ-011 SHALL have port seg  output  7  registered segments, active-low; seg[0]=a through seg[6]=g.
REQ-012 SHALL have port an  output  DIGITS  registered digit select, active-low, at most one bit low.
REQ-013 SHALL have port frame  output  1  one-cycle pulse per completed scan.

Function
REQ-014 SHALL hold a shadow register of width 4*DIGITS, loaded from num at each edge where ld=1; seg/an derive only from the shadow.
REQ-015 SHALL run a prescaler 0..SCAN_DIV-1, wrapping to 0; its terminal count advances the digit index 0..DIGITS-1, wrapping DIGITS-1 -> 0.
REQ-016 SHALL keep prescaler, index and blink state running regardless of en.
REQ-017 SHALL register seg and an from the current index and shadow, so ld high at edge k updates seg no later than edge k+1.
REQ-018 SHALL encode nibbles as (hex, gfedcba active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-019 SHALL drive an with only bit[index] low when en=1, and an all ones with seg=7F when en=0.
REQ-020 SHALL, when lzb=1, blank digit i (seg=7F, an still driven) when i>0 and shadow nibbles i..DIGITS-1 are all zero; digit 0 is never blanked by lzb.
REQ-021 SHALL toggle a blink phase bit after every BLINK_FRAMES completed frames; while phase=1, a digit with blink_mask[i]=1 is blanked (seg=7F).
REQ-022 SHALL pulse frame high for exactly one cycle, on the edge after the index wraps DIGITS-1 -> 0.
REQ-023 SHALL, when ld and an index advance coincide, use the newly loaded shadow for the newly selected digit.
REQ-024 SHALL give blanking the precedence en=0, then lzb, then blink; seg=7F in every blanked case.
REQ-025 SHALL, with DIGITS=1, leave the index at 0, pulse frame once per SCAN_DIV cycles, and never blank the digit via lzb.

Reset
REQ-026 SHALL, while rst_n=0, immediately force shadow=0, prescaler=0, index=0, blink phase=0, an=all ones, seg=7F and frame=0, including mid-scan.
REQ-027 SHALL start the first digit-0 period on the first rising edge after rst_n deasserts, with a full SCAN_DIV duration.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 SHALL test: ld with num=16'h12AF, en=1 -> an cycles E,D,B,7 for 4 clks each; seg = 0E,08,24,79 respectively; frame pulses every 16 clks.
REQ-029 SHALL test: num=16'h0005, lzb=1 -> digit 0 seg=12; digits 1-3 seg=7F with their an bits still low in turn.
REQ-030 SHALL test: num=16'h0000, lzb=1 -> digit 0 shows 40; digits 1-3 blank.
REQ-031 SHALL test: blink_mask=4'b0010, num=16'h8888 -> digit 1 shows 00 for 2 frames, then 7F for 2 frames, repeating; other digits always show 00.
REQ-032 SHALL test: en dropped mid-digit -> an=F and seg=7F next edge; en restored -> scan resumes at the index the free-running counter has reached.
REQ-033 SHALL test: rst_n pulsed low mid-scan with num loaded -> an=F, seg=7F, frame=0 asynchronously; after release digit 0 shows 40 (shadow cleared).
